baud_gen_frac_of_verifla: RTL
=============================

Name: baud_gen_frac_of_verifla

Overview:
Parametrised baud-rate generator for the logic analyser's UART link. It succeeds the fixed-divisor baud block with four additions:
- runtime-programmable integer and fractional divisor;
- an oversample tick for the receiver;
- a mid-bit sample tick;
- a 50%-duty baud clock.

It sits between sys_clk and the UART TX/RX state machines.

Parameters:
CNT_WIDTH, 16, width of the integer divisor and period counter
FRAC_WIDTH, 4, width of the fractional divisor and phase accumulator
OVERSAMPLE, 16, os_ticks per bit; power of two, at least 2
DEFAULT_DIV_INT, 27, integer divisor loaded at reset
DEFAULT_DIV_FRAC, 0, fractional divisor loaded at reset

Ports:
sys_clk  in  1  system clock; all logic on its rising edge
sys_rst  in  1  synchronous, active-high reset
en  in  1  count enable
div_load  in  1  one-cycle strobe; capture div_int_in and div_frac_in
div_int_in  in  CNT_WIDTH  new integer divisor (sys_clk cycles per os_tick)
div_frac_in  in  FRAC_WIDTH  new fractional divisor, in units of 1/2^FRAC_WIDTH cycle
div_busy  out  1  a captured divisor is pending and not yet applied
os_tick  out  1  one-cycle oversample pulse
half_tick  out  1  one-cycle mid-bit pulse
baud_tick  out  1  one-cycle bit-boundary pulse (the baud_clk posedge)
baud_clk  out  1  level baud clock, 50% duty at os_tick granularity

Behaviour:
Reset and enable:
- sys_rst is synchronous and active-high; it has priority over every other input.
- On reset: period counter = 0; os_cnt = 0; acc = 0; ext = 0; active divisor = DEFAULT_*; shadow cleared.
- Reset values of outputs: div_busy=0, os_tick=0, half_tick=0, baud_tick=0, baud_clk=0.
- en=0: all counters and accumulator hold; tick outputs 0; baud_clk holds its level.

Period generation:
- Period P = max(div_int, 2) + ext.
- Active div_int values 0 or 1 are clamped to 2.
- Each enabled cycle: if counter == P-1, then counter <= 0, os_tick <= 1 (the "wrap"); otherwise counter++ and os_tick <= 0.
- All tick outputs are registered.
- The first os_tick after reset is high in the cycle after the div_int-th enabled edge.

Fractional accumulator:
- At each wrap: {carry, acc} <= acc + div_frac, and ext <= carry.
- ext therefore lengthens the next period by one cycle.
- div_frac=0 gives an exact integer period.

Oversample counter:
- os_cnt (width log2(OVERSAMPLE)) increments at each wrap and rolls OVERSAMPLE-1 -> 0.
- baud_tick <= 1 on the wrap where os_cnt goes OVERSAMPLE-1 -> 0; baud_clk <= 1 on the same wrap.
- half_tick <= 1 on the wrap where os_cnt goes OVERSAMPLE/2-1 -> OVERSAMPLE/2; baud_clk <= 0 on the same wrap.
- baud_tick and half_tick always coincide with an os_tick.

Divisor load:
- div_load captures the inputs into the shadow register and sets div_busy.
- The shadow is applied at the next wrap, and that wrap's accumulator update uses the new div_frac.
- If en=0, the shadow is applied on the cycle after capture.
- div_busy clears in the cycle the new divisor is applied.
- div_load in the same cycle as a wrap: the current period is not affected; the new value applies at the following wrap.
- A second div_load while busy overwrites the shadow (last wins).
- acc, os_cnt and baud_clk are not cleared on a divisor load.

Reset mid-operation:
- Outputs take their reset values on the next edge.
- Any pending load is discarded.

Optional Feature:
Macro BAUD_RESYNC_EN.
- Defined: adds input port `resync` (1 bit), intended for the RX start-bit edge.
  - A resync pulse clears counter, os_cnt, acc, ext and baud_clk, and forces all ticks to 0 that cycle.
  - A pending shadow divisor is applied immediately and div_busy clears.
  - resync has priority over a wrap in the same cycle; sys_rst has priority over resync.
  - The first os_tick after resync follows div_int enabled edges.
- Not defined: no resync port and no extra logic. Behaviour is exactly as in the sections above.

Test Plan:
1. Reset, then en=1 with defaults overridden by div_int=4, div_frac=0 and OVERSAMPLE=16 -> os_tick every 4 cycles; half_tick and baud_tick every 64 cycles, 32 cycles apart; baud_clk high 32 cycles, low 32 cycles.
2. div_int=4, div_frac=8 (FRAC_WIDTH=4) -> os_tick periods 4,4,5,4,5,...; os_tick #2 to #34 spans exactly 144 cycles.
3. div_load of div_int=6 midway through a 4-cycle period -> current period still 4; div_busy high until that wrap; following periods 6. Repeat with div_load coincident with a wrap -> one more period of 4, then 6.
4. Load div_int=1 and then div_int=0 -> os_tick every 2 cycles in both cases. en low for 10 cycles mid-period -> counter holds and the remaining period resumes unchanged.
5. sys_rst asserted for one cycle mid-bit with a load pending -> next cycle all outputs 0 and div_busy=0; the divisor reverts to DEFAULT_DIV_INT=27 and the first os_tick comes after 27 edges.
6. BAUD_RESYNC_EN defined, div_int=4: resync at os_cnt=9 -> os_cnt=0 and baud_clk=0; next os_tick after 4 edges; baud_tick 64 cycles after the resync. With resync and a wrap in the same cycle -> no os_tick that cycle.

Source files
------------

// File: rtl/baud_gen_frac_of_verifla.sv
// Fractional baud-rate generator: programmable int/frac divisor, oversample, mid-bit and baud ticks.
// Optional BAUD_RESYNC_EN adds a resync input that realigns the bit timing to an RX start edge.
module baud_gen_frac_of_verifla #(
  parameter int CNT_WIDTH        = 16,
  parameter int FRAC_WIDTH       = 4,
  parameter int OVERSAMPLE       = 16,
  parameter int DEFAULT_DIV_INT  = 27,
  parameter int DEFAULT_DIV_FRAC = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  en,
`ifdef BAUD_RESYNC_EN
  input  logic                  resync,
`endif
  input  logic                  div_load,
  input  logic [CNT_WIDTH-1:0]  div_int_in,
  input  logic [FRAC_WIDTH-1:0] div_frac_in,
  output logic                  div_busy,
  output logic                  os_tick,
  output logic                  half_tick,
  output logic                  baud_tick,
  output logic                  baud_clk
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST      = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);

  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  div_int;
  logic [CNT_WIDTH-1:0]  shadow_int;
  logic [FRAC_WIDTH-1:0] div_frac;
  logic [FRAC_WIDTH-1:0] shadow_frac;
  logic [FRAC_WIDTH-1:0] acc;
  logic                  ext;
  logic [OS_W-1:0]       os_cnt;

  logic [CNT_WIDTH-1:0]  div_eff;
  logic [CNT_WIDTH:0]    period_last;
  logic                  wrap;
  logic                  resync_hit;
  logic                  apply;
  logic [FRAC_WIDTH-1:0] frac_used;
  logic [FRAC_WIDTH:0]   acc_sum;

  // The >= compare keeps the counter from running away if a shorter divisor
  // is applied while the counter already sits past the new terminal count.
  always_comb begin
    div_eff     = (div_int < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : div_int;
    period_last = {1'b0, div_eff} + (CNT_WIDTH+1)'(ext) - (CNT_WIDTH+1)'(1);
    wrap        = en && ({1'b0, cnt} >= period_last);
`ifdef BAUD_RESYNC_EN
    resync_hit  = resync;
`else
    resync_hit  = 1'b0;
`endif
    apply       = div_busy && (resync_hit || wrap || !en);
    frac_used   = apply ? shadow_frac : div_frac;
    acc_sum     = {1'b0, acc} + {1'b0, frac_used};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt         <= '0;
      os_cnt      <= '0;
      acc         <= '0;
      ext         <= 1'b0;
      div_int     <= CNT_WIDTH'(DEFAULT_DIV_INT);
      div_frac    <= FRAC_WIDTH'(DEFAULT_DIV_FRAC);
      shadow_int  <= '0;
      shadow_frac <= '0;
      div_busy    <= 1'b0;
      os_tick     <= 1'b0;
      half_tick   <= 1'b0;
      baud_tick   <= 1'b0;
      baud_clk    <= 1'b0;
    end else begin
      os_tick   <= 1'b0;
      half_tick <= 1'b0;
      baud_tick <= 1'b0;

      // A load landing on the apply cycle stays pending: the old shadow is applied now.
      if (div_load) begin
        shadow_int  <= div_int_in;
        shadow_frac <= div_frac_in;
        div_busy    <= 1'b1;
      end else if (apply) begin
        div_busy    <= 1'b0;
      end

      if (apply) begin
        div_int  <= shadow_int;
        div_frac <= shadow_frac;
      end

      if (resync_hit) begin
        cnt      <= '0;
        os_cnt   <= '0;
        acc      <= '0;
        ext      <= 1'b0;
        baud_clk <= 1'b0;
      end else if (wrap) begin
        cnt            <= '0;
        os_tick        <= 1'b1;
        {ext, acc}     <= acc_sum;
        os_cnt         <= os_cnt + OS_W'(1);
        if (os_cnt == OS_LAST) begin
          baud_tick <= 1'b1;
          baud_clk  <= 1'b1;
        end
        if (os_cnt == OS_HALF_LAST) begin
          half_tick <= 1'b1;
          baud_clk  <= 1'b0;
        end
      end else if (en) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
